// File: rtl/mem_arbiter.sv
// Single-port bus arbiter between instruction fetch and the MEM stage.
// Data requests win over fetch; one transaction in flight, ack-or-timeout.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_inst,
  output logic        if_ready,
  output logic        if_stall,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, GRANT_MEM, GRANT_IF, RESP} stateT;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  stateT       state;
  logic [7:0]  waitCnt;
  logic        timedOut;
  logic        grantDone;
  logic [31:0] respData;

  // Writes return zero; a timeout (no ack) also returns zero.
  assign timedOut  = (waitCnt == TIMEOUT_LAST);
  assign grantDone = bus_ack || timedOut;
  assign respData  = (bus_ack && !bus_we) ? bus_rdata : 32'd0;

  assign if_stall  = if_req & ~if_ready;
  assign mem_stall = mem_req & ~mem_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      waitCnt   <= 8'd0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_sel   <= 4'd0;
      bus_wdata <= 32'd0;
      bus_err   <= 1'b0;
      if_ready  <= 1'b0;
      if_inst   <= 32'd0;
      mem_ready <= 1'b0;
      mem_rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            state     <= GRANT_MEM;
            waitCnt   <= 8'd0;
            bus_req   <= 1'b1;
            bus_we    <= mem_we;
            bus_addr  <= mem_addr;
            bus_sel   <= mem_sel;
            bus_wdata <= mem_wdata;
          end else if (if_req) begin
            state     <= GRANT_IF;
            waitCnt   <= 8'd0;
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= if_addr;
            bus_sel   <= 4'b1111;
            bus_wdata <= 32'd0;
          end
        end
        GRANT_MEM, GRANT_IF: begin
          if (grantDone) begin
            state   <= RESP;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            // Ack arriving on the final wait cycle still counts as success.
            bus_err <= !bus_ack;
            if (state == GRANT_MEM) begin
              mem_ready <= 1'b1;
              mem_rdata <= respData;
            end else begin
              if_ready <= 1'b1;
              if_inst  <= respData;
            end
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          bus_err   <= 1'b0;
          if_ready  <= 1'b0;
          if_inst   <= 32'd0;
          mem_ready <= 1'b0;
          mem_rdata <= 32'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
